// File: rtl/prt_table_if.sv
// Handshake bundle between the MPD (master) and the packet reference table (slave).
// Signal names follow the method-style EN/RDY pairing used on the MPD side.
interface prt_table_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 16
) ();
  localparam int SW = $clog2(NUM_SLOTS);

  logic                  EN_start_writing_prt_entry;
  logic                  RDY_start_writing_prt_entry;
  logic [SW-1:0]         start_writing_prt_entry;
  logic                  EN_write_prt_entry;
  logic                  RDY_write_prt_entry;
  logic [DATA_WIDTH-1:0] write_prt_entry_data;
  logic                  EN_finish_writing_prt_entry;
  logic                  RDY_finish_writing_prt_entry;
  logic                  EN_invalidate_prt_entry;
  logic                  RDY_invalidate_prt_entry;
  logic [SW-1:0]         invalidate_prt_entry_slot;
  logic                  EN_start_reading_prt_entry;
  logic                  RDY_start_reading_prt_entry;
  logic [SW-1:0]         start_reading_prt_entry_slot;
  logic                  EN_read_prt_entry;
  logic                  RDY_read_prt_entry;
  logic [DATA_WIDTH:0]   read_prt_entry;
  logic                  is_prt_slot_free;
  logic                  RDY_is_prt_slot_free;

  modport master (
    output EN_start_writing_prt_entry, EN_write_prt_entry, write_prt_entry_data,
           EN_finish_writing_prt_entry, EN_invalidate_prt_entry, invalidate_prt_entry_slot,
           EN_start_reading_prt_entry, start_reading_prt_entry_slot, EN_read_prt_entry,
    input  RDY_start_writing_prt_entry, start_writing_prt_entry, RDY_write_prt_entry,
           RDY_finish_writing_prt_entry, RDY_invalidate_prt_entry, RDY_start_reading_prt_entry,
           RDY_read_prt_entry, read_prt_entry, is_prt_slot_free, RDY_is_prt_slot_free
  );

  modport slave (
    input  EN_start_writing_prt_entry, EN_write_prt_entry, write_prt_entry_data,
           EN_finish_writing_prt_entry, EN_invalidate_prt_entry, invalidate_prt_entry_slot,
           EN_start_reading_prt_entry, start_reading_prt_entry_slot, EN_read_prt_entry,
    output RDY_start_writing_prt_entry, start_writing_prt_entry, RDY_write_prt_entry,
           RDY_finish_writing_prt_entry, RDY_invalidate_prt_entry, RDY_start_reading_prt_entry,
           RDY_read_prt_entry, read_prt_entry, is_prt_slot_free, RDY_is_prt_slot_free
  );
endinterface

// File: rtl/prt_table.sv
// Packet reference table: NUM_SLOTS buffers of up to MAX_BEATS words, one write and one
// read transaction in flight at a time, plus slot invalidation.
// Optional macro PRT_STATS_EN adds saturating commit/invalidate/abort counters.
//
// state    | meaning
// W_IDLE   | no write open; start allocates the lowest free slot
// W_ACTIVE | words being pushed into wr_slot; finish commits, invalidate aborts
// R_IDLE   | no read open
// R_ACTIVE | read_prt_entry presents beat rd_ptr of rd_slot (or one empty beat)
module prt_table #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 16,
  parameter int MAX_BEATS  = 8,
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int BW = $clog2(MAX_BEATS + 1),
  localparam int IW = $clog2(MAX_BEATS)
) (
  input  logic           CLK,
  input  logic           RST,
  prt_table_if.slave     bus
`ifdef PRT_STATS_EN
  ,
  output logic [15:0]    stat_committed,
  output logic [15:0]    stat_invalidated,
  output logic [15:0]    stat_aborted
`endif
);

  typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;
  typedef enum logic {R_IDLE, R_ACTIVE} r_state_t;

  w_state_t              w_state;
  r_state_t              r_state;
  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS][MAX_BEATS];
  logic [NUM_SLOTS-1:0]  valid;
  logic [BW-1:0]         len [NUM_SLOTS];
  logic [SW-1:0]         wr_slot, rd_slot, alloc_slot;
  logic [BW-1:0]         wr_cnt, rd_ptr, commit_len;
  logic                  rd_empty, rd_last, any_free;
  logic                  do_sw, do_w, do_f, do_inv, do_sr, do_r, w_abort, r_abort;

  // Lowest-index free slot; the slot under construction is never free.
  always_comb begin
    alloc_slot = '0;
    any_free   = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid[i] && !(w_state == W_ACTIVE && wr_slot == SW'(i))) begin
        alloc_slot = SW'(i);
        any_free   = 1'b1;
      end
    end
  end

  assign bus.RDY_start_writing_prt_entry  = (w_state == W_IDLE) && any_free;
  assign bus.start_writing_prt_entry      = alloc_slot;
  assign bus.RDY_write_prt_entry          = (w_state == W_ACTIVE) && (wr_cnt < BW'(MAX_BEATS));
  assign bus.RDY_finish_writing_prt_entry = (w_state == W_ACTIVE) && (wr_cnt != '0);
  assign bus.RDY_invalidate_prt_entry     = 1'b1;
  assign bus.RDY_start_reading_prt_entry  = (r_state == R_IDLE);
  assign bus.RDY_read_prt_entry           = (r_state == R_ACTIVE);
  assign bus.is_prt_slot_free             = any_free;
  assign bus.RDY_is_prt_slot_free         = 1'b1;

  assign do_sw   = bus.EN_start_writing_prt_entry  && bus.RDY_start_writing_prt_entry;
  assign do_w    = bus.EN_write_prt_entry          && bus.RDY_write_prt_entry;
  assign do_f    = bus.EN_finish_writing_prt_entry && bus.RDY_finish_writing_prt_entry;
  assign do_inv  = bus.EN_invalidate_prt_entry;
  assign do_sr   = bus.EN_start_reading_prt_entry  && bus.RDY_start_reading_prt_entry;
  assign do_r    = bus.EN_read_prt_entry           && bus.RDY_read_prt_entry;
  assign w_abort = do_inv && (w_state == W_ACTIVE) && (bus.invalidate_prt_entry_slot == wr_slot);
  assign r_abort = do_inv && (r_state == R_ACTIVE) && (bus.invalidate_prt_entry_slot == rd_slot);

  // A finish in the same cycle as a write includes that word in the committed length.
  assign commit_len = do_w ? wr_cnt + BW'(1) : wr_cnt;
  assign rd_last    = rd_empty || (rd_ptr == len[rd_slot] - BW'(1));

  assign bus.read_prt_entry = (r_state != R_ACTIVE) ? '0 :
                              rd_empty ? {1'b1, {DATA_WIDTH{1'b0}}} :
                              {rd_last, mem[rd_slot][rd_ptr[IW-1:0]]};

  // Packet word storage; contents are deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (do_w) mem[wr_slot][wr_cnt[IW-1:0]] <= bus.write_prt_entry_data;
  end

  // Write FSM, read FSM and slot bookkeeping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      valid    <= '0;
      wr_slot  <= '0;
      rd_slot  <= '0;
      wr_cnt   <= '0;
      rd_ptr   <= '0;
      rd_empty <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) len[i] <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (do_sw) begin
            wr_slot <= alloc_slot;
            wr_cnt  <= '0;
            w_state <= W_ACTIVE;
          end
        end
        W_ACTIVE: begin
          if (w_abort) begin
            w_state <= W_IDLE;
          end else begin
            if (do_w) wr_cnt <= wr_cnt + BW'(1);
            if (do_f) begin
              valid[wr_slot] <= 1'b1;
              len[wr_slot]   <= commit_len;
              w_state        <= W_IDLE;
            end
          end
        end
        default: w_state <= W_IDLE;
      endcase

      if (do_inv) begin
        valid[bus.invalidate_prt_entry_slot] <= 1'b0;
        len[bus.invalidate_prt_entry_slot]   <= '0;
      end

      case (r_state)
        R_IDLE: begin
          if (do_sr) begin
            rd_slot  <= bus.start_reading_prt_entry_slot;
            rd_ptr   <= '0;
            // A slot invalidated in the same cycle must not be read as if still valid.
            rd_empty <= !valid[bus.start_reading_prt_entry_slot] ||
                        (do_inv && bus.invalidate_prt_entry_slot == bus.start_reading_prt_entry_slot);
            r_state  <= R_ACTIVE;
          end
        end
        R_ACTIVE: begin
          if (r_abort) begin
            r_state <= R_IDLE;
          end else if (do_r) begin
            if (rd_last) r_state <= R_IDLE;
            else         rd_ptr  <= rd_ptr + BW'(1);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef PRT_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + 17'(inc);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Saturating event counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_committed   <= '0;
      stat_invalidated <= '0;
      stat_aborted     <= '0;
    end else begin
      stat_committed   <= sat_add(stat_committed, {1'b0, do_f && !w_abort});
      stat_invalidated <= sat_add(stat_invalidated,
                                  {1'b0, do_inv && valid[bus.invalidate_prt_entry_slot]});
      stat_aborted     <= sat_add(stat_aborted, 2'(w_abort) + 2'(r_abort));
    end
  end
`endif

endmodule

// File: tb/tb_prt_table.sv
// Directed bench for prt_table: a vector table of single-cycle operations followed by
// hand-written sequences for fill/overflow/abort/reset corner cases.
module tb_prt_table;
  logic CLK = 1'b0;
  logic RST = 1'b1;

  prt_table_if #(.DATA_WIDTH(32), .NUM_SLOTS(16)) bus ();

`ifdef PRT_STATS_EN
  logic [15:0] st_c, st_i, st_a;
`endif

  prt_table #(.DATA_WIDTH(32), .NUM_SLOTS(16), .MAX_BEATS(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef PRT_STATS_EN
    ,
    .stat_committed   (st_c),
    .stat_invalidated (st_i),
    .stat_aborted     (st_a)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // en = {start_w, write, finish, invalidate, start_r, read}
  // ef = {rdy_start_w, rdy_write, rdy_finish, rdy_start_r, rdy_read, slot_free}
  typedef struct {
    logic [5:0]  en;
    logic [31:0] wd;
    logic [3:0]  islot;
    logic [3:0]  rslot;
    logic [5:0]  ef;
    logic [3:0]  eslot;
    logic [32:0] erd;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_en();
    bus.EN_start_writing_prt_entry  = 1'b0;
    bus.EN_write_prt_entry          = 1'b0;
    bus.EN_finish_writing_prt_entry = 1'b0;
    bus.EN_invalidate_prt_entry     = 1'b0;
    bus.EN_start_reading_prt_entry  = 1'b0;
    bus.EN_read_prt_entry           = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    clear_en();
  endtask

  task automatic check_state(input string tag, input logic [5:0] ef, input logic [3:0] eslot,
                             input logic [32:0] erd);
    chk({tag, " rdy_start_w"}, 64'(bus.RDY_start_writing_prt_entry), 64'(ef[5]));
    chk({tag, " rdy_write"},   64'(bus.RDY_write_prt_entry),          64'(ef[4]));
    chk({tag, " rdy_finish"},  64'(bus.RDY_finish_writing_prt_entry), 64'(ef[3]));
    chk({tag, " rdy_start_r"}, 64'(bus.RDY_start_reading_prt_entry),  64'(ef[2]));
    chk({tag, " rdy_read"},    64'(bus.RDY_read_prt_entry),           64'(ef[1]));
    chk({tag, " slot_free"},   64'(bus.is_prt_slot_free),             64'(ef[0]));
    chk({tag, " alloc_slot"},  64'(bus.start_writing_prt_entry),      64'(eslot));
    chk({tag, " read_data"},   64'(bus.read_prt_entry),               64'(erd));
  endtask

  task automatic op_start_w();
    bus.EN_start_writing_prt_entry = 1'b1;
    tick();
  endtask

  task automatic op_write(input logic [31:0] d);
    bus.EN_write_prt_entry   = 1'b1;
    bus.write_prt_entry_data = d;
    tick();
  endtask

  task automatic op_finish();
    bus.EN_finish_writing_prt_entry = 1'b1;
    tick();
  endtask

  task automatic op_inv(input logic [3:0] s);
    bus.EN_invalidate_prt_entry   = 1'b1;
    bus.invalidate_prt_entry_slot = s;
    tick();
  endtask

  task automatic op_start_r(input logic [3:0] s);
    bus.EN_start_reading_prt_entry   = 1'b1;
    bus.start_reading_prt_entry_slot = s;
    tick();
  endtask

  task automatic op_read();
    bus.EN_read_prt_entry = 1'b1;
    tick();
  endtask

  initial begin
    clear_en();
    bus.write_prt_entry_data         = '0;
    bus.invalidate_prt_entry_slot    = '0;
    bus.start_reading_prt_entry_slot = '0;

    vt[0]  = '{6'b100000, 32'h0,  4'd0, 4'd0, 6'b010101, 4'd1, 33'h0};
    vt[1]  = '{6'b010000, 32'hA1, 4'd0, 4'd0, 6'b011101, 4'd1, 33'h0};
    vt[2]  = '{6'b010000, 32'hA2, 4'd0, 4'd0, 6'b011101, 4'd1, 33'h0};
    vt[3]  = '{6'b010000, 32'hA3, 4'd0, 4'd0, 6'b011101, 4'd1, 33'h0};
    vt[4]  = '{6'b001000, 32'h0,  4'd0, 4'd0, 6'b100101, 4'd1, 33'h0};
    vt[5]  = '{6'b000010, 32'h0,  4'd0, 4'd0, 6'b100011, 4'd1, 33'h0_000000A1};
    vt[6]  = '{6'b000001, 32'h0,  4'd0, 4'd0, 6'b100011, 4'd1, 33'h0_000000A2};
    vt[7]  = '{6'b000001, 32'h0,  4'd0, 4'd0, 6'b100011, 4'd1, 33'h1_000000A3};
    vt[8]  = '{6'b000001, 32'h0,  4'd0, 4'd0, 6'b100101, 4'd1, 33'h0};
    vt[9]  = '{6'b000001, 32'h0,  4'd0, 4'd0, 6'b100101, 4'd1, 33'h0};
    vt[10] = '{6'b000010, 32'h0,  4'd0, 4'd3, 6'b100011, 4'd1, 33'h1_00000000};
    vt[11] = '{6'b000001, 32'h0,  4'd0, 4'd0, 6'b100101, 4'd1, 33'h0};
    vt[12] = '{6'b000100, 32'h0,  4'd0, 4'd0, 6'b100101, 4'd0, 33'h0};
    vt[13] = '{6'b000100, 32'h0,  4'd0, 4'd0, 6'b100101, 4'd0, 33'h0};
    vt[14] = '{6'b100100, 32'h0,  4'd7, 4'd0, 6'b010101, 4'd1, 33'h0};
    vt[15] = '{6'b010000, 32'hB1, 4'd0, 4'd0, 6'b011101, 4'd1, 33'h0};
    vt[16] = '{6'b010010, 32'hB2, 4'd0, 4'd0, 6'b011011, 4'd1, 33'h1_00000000};
    vt[17] = '{6'b000101, 32'h0,  4'd0, 4'd0, 6'b100101, 4'd0, 33'h0};
    vt[18] = '{6'b001000, 32'h0,  4'd0, 4'd0, 6'b100101, 4'd0, 33'h0};

    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_state("reset", 6'b100101, 4'd0, 33'h0);

    for (int i = 0; i < 19; i++) begin
      bus.EN_start_writing_prt_entry   = vt[i].en[5];
      bus.EN_write_prt_entry           = vt[i].en[4];
      bus.EN_finish_writing_prt_entry  = vt[i].en[3];
      bus.EN_invalidate_prt_entry      = vt[i].en[2];
      bus.EN_start_reading_prt_entry   = vt[i].en[1];
      bus.EN_read_prt_entry            = vt[i].en[0];
      bus.write_prt_entry_data         = vt[i].wd;
      bus.invalidate_prt_entry_slot    = vt[i].islot;
      bus.start_reading_prt_entry_slot = vt[i].rslot;
      tick();
      check_state($sformatf("vec%0d", i), vt[i].ef, vt[i].eslot, vt[i].erd);
    end

    // Fill every slot with a single word.
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill alloc%0d", i), 64'(bus.start_writing_prt_entry), 64'(i));
      op_start_w();
      op_write(32'hC0 + 32'(i));
      op_finish();
    end
    chk("full slot_free", 64'(bus.is_prt_slot_free), 64'd0);
    chk("full rdy_start_w", 64'(bus.RDY_start_writing_prt_entry), 64'd0);
    op_inv(4'd5);
    chk("inv5 alloc", 64'(bus.start_writing_prt_entry), 64'd5);
    chk("inv5 rdy_start_w", 64'(bus.RDY_start_writing_prt_entry), 64'd1);
    chk("inv5 slot_free", 64'(bus.is_prt_slot_free), 64'd1);
    op_start_r(4'd15);
    chk("slot15 beat", 64'(bus.read_prt_entry), 64'h1_000000CF);
    op_read();
    chk("slot15 done", 64'(bus.RDY_read_prt_entry), 64'd0);

    // Maximum-length packet into slot 5; a ninth word must be refused.
    op_start_w();
    for (int k = 0; k < 8; k++) op_write(32'hD0 + 32'(k));
    chk("max rdy_write", 64'(bus.RDY_write_prt_entry), 64'd0);
    chk("max rdy_finish", 64'(bus.RDY_finish_writing_prt_entry), 64'd1);
    op_write(32'hDEAD);
    chk("ovf rdy_finish", 64'(bus.RDY_finish_writing_prt_entry), 64'd1);
    op_finish();
    chk("max full", 64'(bus.is_prt_slot_free), 64'd0);
    op_start_r(4'd5);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("max beat%0d", k), 64'(bus.read_prt_entry),
          {31'd0, (k == 7), 32'hD0 + 32'(k)});
      op_read();
    end
    chk("max done", 64'(bus.RDY_read_prt_entry), 64'd0);

    // Abort a read in progress by invalidating its slot.
    op_start_r(4'd5);
    op_read();
    op_read();
    chk("rabort beat2", 64'(bus.read_prt_entry), 64'h0_000000D2);
    op_inv(4'd5);
    chk("rabort rdy_read", 64'(bus.RDY_read_prt_entry), 64'd0);
    chk("rabort rdy_start_r", 64'(bus.RDY_start_reading_prt_entry), 64'd1);
    chk("rabort alloc", 64'(bus.start_writing_prt_entry), 64'd5);

    // Reset in the middle of a read and a write.
    op_start_w();
    op_write(32'hE0);
    op_start_r(4'd1);
    chk("prerst beat", 64'(bus.read_prt_entry), 64'h1_000000C1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_state("midrst", 6'b100101, 4'd0, 33'h0);
    op_start_r(4'd1);
    chk("postrst slot1 empty", 64'(bus.read_prt_entry), 64'h1_00000000);
    op_read();
    chk("postrst done", 64'(bus.RDY_read_prt_entry), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
